// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the double-buffered frame store.
package fb_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

  typedef logic [15:0] rgb565_t;

  // Number of pixels in one bank.
  function automatic int fb_depth(input int width, input int height);
    return width * height;
  endfunction

  // Address bits needed to index one bank (at least one bit).
  function automatic int fb_addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FB_DEFAULT_DEPTH = fb_depth(320, 180);

endpackage

// File: rtl/frame_buffer_if.sv
// Render-side write strobe and scanout signals of the frame buffer.
//
// Handshake: new_pixel_in is a one-cycle strobe with no backpressure. It is
// taken in the same cycle it is sampled only while ready_out is high and
// addr_in addresses a pixel inside the frame; any other strobe is discarded
// (never retried) and counted in dropped_count_out. frame_done_in and
// vsync_in are one-cycle pulses; swap_out pulses once per bank swap.
interface frame_buffer_if;
  import fb_pkg::*;

  logic        new_pixel_in;
  logic [15:0] addr_in;
  rgb565_t     color_in;
  logic        frame_done_in;
  logic        vsync_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  rgb565_t     pixel_out;
  logic        ready_out;
  logic        swap_out;
  logic [15:0] dropped_count_out;

  modport master (
    output new_pixel_in, addr_in, color_in, frame_done_in, vsync_in,
           hcount_in, vcount_in,
    input  pixel_out, ready_out, swap_out, dropped_count_out
  );

  modport slave (
    input  new_pixel_in, addr_in, color_in, frame_done_in, vsync_in,
           hcount_in, vcount_in,
    output pixel_out, ready_out, swap_out, dropped_count_out
  );

endinterface

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM, one write port, one registered read.
module fb_bank
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEFAULT_DEPTH,
  parameter int AW    = fb_addr_bits(DEPTH)
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb565_t       wdata,
  input  logic [AW-1:0] raddr,
  output rgb565_t       rdata
);

  rgb565_t mem [DEPTH];

  // Write port and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered RGB565 frame store: render writes the back bank while
// scanout reads the front bank; banks swap on vsync after frame_done, and the
// new back bank is cleared before drawing resumes.
module frame_buffer
  import fb_pkg::*;
#(
  parameter int      WIDTH       = 320,
  parameter int      HEIGHT      = 180,
  parameter rgb565_t CLEAR_COLOR = 16'h0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  frame_buffer_if.slave bus,
  output fb_state_t     state_dbg
);

  localparam int DEPTH = fb_depth(WIDTH, HEIGHT);
  localparam int AW    = fb_addr_bits(DEPTH);

  // Linear addresses are 16 bits wide, so one bank can hold at most 64K pixels.
  if (DEPTH > 65536 || DEPTH < 1) begin : g_depth_check
    $error("frame_buffer: WIDTH*HEIGHT must be in 1..65536");
  end

  fb_state_t   state_q, state_d;
  logic [15:0] clr_cnt_q;
  logic        front_sel_q;
  logic        ready_q, swap_q;
  logic [15:0] dropped_q;

  logic          addr_ok, clear_last;
  logic          wr_en, reject, do_swap;
  logic [AW-1:0] wr_addr;
  rgb565_t       wr_data;
  logic [1:0]    bank_we;

  logic [AW-1:0] scan_addr_q;
  logic          blank_q1, blank_q2, sel_q;
  rgb565_t       rdata [2];

  assign addr_ok    = 17'(bus.addr_in) < 17'(DEPTH);
  assign clear_last = clr_cnt_q == 16'(DEPTH - 1);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next state: clear the whole back bank, draw until frame_done, wait for vsync.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:     if (clear_last)        state_d = DRAW;
      DRAW:      if (bus.frame_done_in) state_d = WAIT_SWAP;
      WAIT_SWAP: if (bus.vsync_in)      state_d = CLEAR;
      default:                          state_d = CLEAR;
    endcase
  end

  // Per-state actions: back-bank write source, rejected strobes, swap request.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr_in[AW-1:0];
    wr_data = bus.color_in;
    reject  = 1'b0;
    do_swap = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q[AW-1:0];
        wr_data = CLEAR_COLOR;
        reject  = bus.new_pixel_in;
      end
      DRAW: begin
        wr_en  = bus.new_pixel_in && addr_ok;
        reject = bus.new_pixel_in && !addr_ok;
      end
      WAIT_SWAP: begin
        reject  = bus.new_pixel_in;
        do_swap = bus.vsync_in;
      end
      default: ;
    endcase
  end

  // Clear counter, bank select, registered ready/swap flags and drop counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clr_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      ready_q     <= 1'b0;
      swap_q      <= 1'b0;
      dropped_q   <= '0;
    end else begin
      clr_cnt_q   <= (state_q == CLEAR && !clear_last) ? clr_cnt_q + 16'd1 : 16'd0;
      front_sel_q <= front_sel_q ^ do_swap;
      ready_q     <= (state_d == DRAW);
      swap_q      <= do_swap;
      if (reject && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  // Scanout pipeline: address + blank flag, then RAM data + bank select.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scan_addr_q <= '0;
      blank_q1    <= 1'b1;
      blank_q2    <= 1'b1;
      sel_q       <= 1'b0;
    end else begin
      scan_addr_q <= AW'(32'(bus.vcount_in) * WIDTH + 32'(bus.hcount_in));
      blank_q1    <= (32'(bus.hcount_in) >= WIDTH) || (32'(bus.vcount_in) >= HEIGHT);
      blank_q2    <= blank_q1;
      sel_q       <= front_sel_q;
    end
  end

  // The back bank is whichever one scanout is not reading.
  assign bank_we[0] = wr_en &  front_sel_q;
  assign bank_we[1] = wr_en & ~front_sel_q;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    fb_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk_in (clk_in),
      .we     (bank_we[i]),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .raddr  (scan_addr_q),
      .rdata  (rdata[i])
    );
  end

  assign bus.pixel_out         = blank_q2 ? 16'h0000 : (sel_q ? rdata[1] : rdata[0]);
  assign bus.ready_out         = ready_q;
  assign bus.swap_out          = swap_q;
  assign bus.dropped_count_out = dropped_q;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer using a small frame and a pixel-image
// reference model (two images, a front index, a drop counter).
module tb_frame_buffer;
  import fb_pkg::*;

  localparam int          W     = 40;
  localparam int          H     = 12;
  localparam int          DEPTH = W * H;
  localparam logic [15:0] CLR   = 16'h1234;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  fb_state_t state_dbg;

  frame_buffer_if bus();

  frame_buffer #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOR(CLR)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] img [2][DEPTH];
  int          m_front   = 0;
  int          m_dropped = 0;
  bit          m_drawing = 0;
  logic [15:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reject();
    if (m_dropped < 65535) m_dropped++;
  endtask

  task automatic model_write(input int a, input logic [15:0] c);
    if (m_drawing && a < DEPTH) img[1 - m_front][a] = c;
    else model_reject();
  endtask

  task automatic model_swap();
    m_front = 1 - m_front;
    for (int i = 0; i < DEPTH; i++) img[1 - m_front][i] = CLR;
    m_drawing = 0;
  endtask

  task automatic model_reset();
    m_front   = 0;
    m_dropped = 0;
    m_drawing = 0;
    for (int i = 0; i < DEPTH; i++) img[1][i] = CLR;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.new_pixel_in  = 1'b0;
    bus.addr_in       = 16'h0;
    bus.color_in      = 16'h0;
    bus.frame_done_in = 1'b0;
    bus.vsync_in      = 1'b0;
    bus.hcount_in     = 11'h0;
    bus.vcount_in     = 10'h0;
  endtask

  task automatic drive_write(input int a, input logic [15:0] c, input bit fd);
    bus.new_pixel_in  = 1'b1;
    bus.addr_in       = 16'(a);
    bus.color_in      = c;
    bus.frame_done_in = fd;
    step();
    bus.new_pixel_in  = 1'b0;
    bus.frame_done_in = 1'b0;
    model_write(a, c);
    if (fd) m_drawing = 0;
  endtask

  task automatic pulse_vsync();
    bus.vsync_in = 1'b1;
    step();
    bus.vsync_in = 1'b0;
  endtask

  task automatic check_dropped(input string name);
    total++;
    if (bus.dropped_count_out !== 16'(m_dropped)) begin
      bad++;
      $display("FAIL %s dropped got=%0d exp=%0d", name, bus.dropped_count_out, m_dropped);
    end
  endtask

  task automatic check_ready(input string name, input logic e);
    total++;
    if (bus.ready_out !== e) begin
      bad++;
      $display("FAIL %s ready got=%b exp=%b", name, bus.ready_out, e);
    end
  endtask

  task automatic check_swap(input string name, input logic e);
    total++;
    if (bus.swap_out !== e) begin
      bad++;
      $display("FAIL %s swap got=%b exp=%b", name, bus.swap_out, e);
    end
  endtask

  // After a long idle stretch the clear must be finished: drawing resumes.
  task automatic expect_drawing(input string name);
    check_ready(name, 1'b1);
    m_drawing = 1;
  endtask

  // Streams every pixel of the frame plus off-screen points through scanout,
  // one new coordinate per cycle, checking each result two cycles later.
  task automatic scan_frame(input string name);
    int ph[$];
    int pv[$];
    int n;
    logic [15:0] e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        ph.push_back(x);
        pv.push_back(y);
      end
    ph.push_back(W);    pv.push_back(0);
    ph.push_back(0);    pv.push_back(H);
    ph.push_back(W);    pv.push_back(H);
    ph.push_back(2047); pv.push_back(1023);
    ph.push_back(0);    pv.push_back(0);
    n = ph.size();
    exp_q.delete();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.hcount_in = 11'(ph[i]);
        bus.vcount_in = 10'(pv[i]);
        if (ph[i] >= W || pv[i] >= H) e = 16'h0000;
        else e = img[m_front][pv[i] * W + ph[i]];
        exp_q.push_back(e);
      end
      step();
      if (i >= 1) begin
        e = exp_q.pop_front();
        total++;
        if (bus.pixel_out !== e) begin
          bad++;
          $display("FAIL %s pixel idx=%0d got=%h exp=%h", name, i - 1, bus.pixel_out, e);
        end
      end
    end
  endtask

  // Counts cycles from reset release: ready low for DEPTH cycles, then high.
  task automatic check_clear_timing(input string name, input bit inject);
    for (int k = 1; k <= DEPTH; k++) begin
      if (inject && k == 10) begin
        bus.new_pixel_in = 1'b1;
        bus.addr_in      = 16'd3;
        bus.color_in     = 16'hBEEF;
      end
      step();
      if (inject && k == 10) begin
        bus.new_pixel_in = 1'b0;
        model_reject();
      end
      check_ready(name, (k == DEPTH) ? 1'b1 : 1'b0);
    end
    m_drawing = 1;
    total++;
    if (state_dbg !== DRAW) begin
      bad++;
      $display("FAIL %s state got=%0d exp=%0d", name, state_dbg, DRAW);
    end
    check_dropped(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    check_ready("reset", 1'b0);
    check_swap("reset", 1'b0);
    check_dropped("reset");
    total++;
    if (bus.pixel_out !== 16'h0000) begin
      bad++;
      $display("FAIL reset pixel got=%h exp=0000", bus.pixel_out);
    end
    total++;
    if (state_dbg !== CLEAR) begin
      bad++;
      $display("FAIL reset state got=%0d exp=%0d", state_dbg, CLEAR);
    end
  endtask

  task automatic test_draw_and_swap();
    int a;
    drive_write(W + 1, 16'hF800, 1'b0);
    drive_write(DEPTH - 1, 16'h07E0, 1'b0);
    drive_write(DEPTH, 16'h001F, 1'b0);
    drive_write(0, 16'hABCD, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 65535))
                                       : int'($urandom_range(0, DEPTH - 1));
      if (a == W + 1) a = W + 2;
      drive_write(a, 16'($urandom), 1'b0);
    end
    drive_write(5, 16'h5A5A, 1'b1);
    check_ready("draw_fd", 1'b0);
    drive_write(7, 16'hDEAD, 1'b0);
    bus.frame_done_in = 1'b1;
    step();
    bus.frame_done_in = 1'b0;
    check_dropped("draw_drops");
    check_swap("draw_pre_vsync", 1'b0);
    pulse_vsync();
    check_swap("draw_vsync", 1'b1);
    check_ready("draw_vsync", 1'b0);
    model_swap();
    bus.frame_done_in = 1'b1;
    step();
    bus.frame_done_in = 1'b0;
    check_swap("draw_swap_end", 1'b0);
    scan_frame("draw_scan");
    expect_drawing("draw_after_clear");
  endtask

  task automatic test_saturate();
    int n;
    drive_write(DEPTH + 5, 16'h1111, 1'b1);
    n = 65535 - m_dropped + 4;
    bus.new_pixel_in = 1'b1;
    bus.addr_in      = 16'd0;
    bus.color_in     = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      step();
      model_reject();
      if (m_dropped == 65534) check_dropped("sat_near");
    end
    bus.new_pixel_in = 1'b0;
    check_dropped("sat_full");
    pulse_vsync();
    check_swap("sat_vsync", 1'b1);
    model_swap();
    for (int i = 0; i < DEPTH + 2; i++) step();
    expect_drawing("sat_after_clear");
    check_dropped("sat_hold");
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 20; i++)
      drive_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
    pulse_vsync();
    check_swap("sim_vsync_in_draw", 1'b0);
    check_ready("sim_vsync_in_draw", 1'b1);
    bus.frame_done_in = 1'b1;
    bus.vsync_in      = 1'b1;
    step();
    bus.frame_done_in = 1'b0;
    bus.vsync_in      = 1'b0;
    m_drawing = 0;
    check_swap("sim_both", 1'b0);
    check_ready("sim_both", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_swap("sim_wait", 1'b0);
    end
    pulse_vsync();
    check_swap("sim_next_vsync", 1'b1);
    model_swap();
    scan_frame("sim_scan");
    expect_drawing("sim_after_clear");
  endtask

  task automatic test_reset_mid_draw();
    for (int i = 0; i < 10; i++)
      drive_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
    bus.hcount_in = 11'd3;
    bus.vcount_in = 10'd2;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    test_reset();
    step();
    rst = 1'b0;
    check_clear_timing("rst_clear", 1'b0);
    for (int i = 0; i < 15; i++)
      drive_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
    drive_write(DEPTH + 1, 16'h2222, 1'b1);
    pulse_vsync();
    check_swap("rst_vsync", 1'b1);
    model_swap();
    scan_frame("rst_scan");
    check_dropped("rst_drops");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    test_reset();
    rst = 1'b0;
    check_clear_timing("clear", 1'b1);
    test_draw_and_swap();
    test_saturate();
    test_simultaneous();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
